data_rule_monitor: RTL and testbench

- Synthesisable, multi-channel data-rule checker, the parametrised successor of the single-channel "enable implies non-zero and even" check.
- Each channel is checked on every enabled clock against a run-time selectable rule set: non-zero, and/or alignment to 2^ALIGN_BITS.
- Produces registered fail pulses, sticky errors, saturating fail counters, first-failure capture and a per-channel consecutive-failure alarm FSM.
- Sits beside datapath blocks as an embedded monitor; its outputs feed status registers and the bench scoreboard.

---
 rtl/data_rule_pkg.sv | 17 +
 rtl/data_rule_chan.sv | 84 ++++++++
 rtl/data_rule_monitor.sv | 98 +++++++++
 tb/tb_data_rule_monitor.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_rule_pkg.sv
// Shared definitions for the data rule monitor.
//   RULE_NZ / RULE_ALIGN : bit positions inside rule_mode
//   chan_state_t         : per-channel alarm FSM state
//   sat_inc              : saturating increment helper (operands up to 32 bits)
package data_rule_pkg;

  localparam int unsigned RULE_NZ    = 0;
  localparam int unsigned RULE_ALIGN = 1;

  typedef enum logic [1:0] {ST_OK, ST_WARN, ST_ALARM} chan_state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] max);
    return (val >= max) ? max : val + 32'd1;
  endfunction

endpackage

// File: rtl/data_rule_chan.sv
// One monitored channel: rule evaluation, saturating fail counter,
// consecutive-fail streak counter, OK/WARN/ALARM FSM, sticky error and
// registered fail pulse.
// Ports:
//   i_clk, i_rst_n    clock, synchronous active-low reset
//   i_enable          check qualifier for this channel
//   i_data            channel data
//   i_rule_mode       bit RULE_NZ = non-zero rule, bit RULE_ALIGN = alignment rule
//   i_clear           synchronous clear of all status state
//   o_fail            combinational failure of the current sample
//   o_fail_pulse      registered one-cycle failure indication
//   o_sticky_err      set on any failure, held until clear
//   o_fail_cnt        saturating failure count
//   o_alarm           FSM is in ST_ALARM
module data_rule_chan
  import data_rule_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned ALIGN_BITS  = 1,
  parameter int unsigned FAIL_THRESH = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic [DATA_W-1:0] i_data,
  input  logic [1:0]        i_rule_mode,
  input  logic              i_clear,
  output logic              o_fail,
  output logic              o_fail_pulse,
  output logic              o_sticky_err,
  output logic [CNT_W-1:0]  o_fail_cnt,
  output logic              o_alarm
);

  logic              w_viol;
  logic              w_fail;
  logic [8:0]        w_consec_inc;
  logic              w_reach;
  logic [7:0]        r_consec;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_pulse;
  logic              r_sticky;
  chan_state_t       r_state;

  always_comb begin
    w_viol = (i_rule_mode[RULE_NZ]    && (i_data == '0)) ||
             (i_rule_mode[RULE_ALIGN] && (i_data[ALIGN_BITS-1:0] != '0));
    w_fail = i_enable && w_viol;
    // 9-bit sum so consec+1 cannot wrap before the threshold compare
    w_consec_inc = {1'b0, r_consec} + 9'd1;
    w_reach      = (w_consec_inc >= 9'(FAIL_THRESH));
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      r_consec <= '0;
      r_cnt    <= '0;
      r_pulse  <= 1'b0;
      r_sticky <= 1'b0;
      r_state  <= ST_OK;
    end else begin
      r_pulse <= w_fail;
      if (w_fail) begin
        r_sticky <= 1'b1;
        r_cnt    <= CNT_W'(sat_inc(32'(r_cnt), 32'({CNT_W{1'b1}})));
        r_consec <= 8'(sat_inc(32'(r_consec), 32'(FAIL_THRESH)));
        if (r_state != ST_ALARM)
          r_state <= w_reach ? ST_ALARM : ST_WARN;
      end else if (i_enable) begin
        r_consec <= '0;
        if (r_state == ST_WARN)
          r_state <= ST_OK;
      end
    end
  end

  assign o_fail       = w_fail;
  assign o_fail_pulse = r_pulse;
  assign o_sticky_err = r_sticky;
  assign o_fail_cnt   = r_cnt;
  assign o_alarm      = (r_state == ST_ALARM);

endmodule

// File: rtl/data_rule_monitor.sv
// Multi-channel data rule monitor: one data_rule_chan per channel plus
// lowest-index-wins capture of the first failure since reset/clear.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   enable            per-channel check qualifier
//   data              channel c at [c*DATA_W +: DATA_W]
//   rule_mode         bit0 non-zero rule, bit1 alignment rule (all channels)
//   clear             synchronous clear of status state (wins over failures)
//   fail_pulse        registered one-cycle failure per channel
//   sticky_err        sticky failure per channel
//   fail_cnt          saturating counters, channel c at [c*CNT_W +: CNT_W]
//   alarm             per-channel alarm FSM in ALARM
//   first_fail_*      valid flag, channel and data of the first failure
module data_rule_monitor
  import data_rule_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned ALIGN_BITS  = 1,
  parameter int unsigned FAIL_THRESH = 3,
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        enable,
  input  logic [NUM_CH*DATA_W-1:0] data,
  input  logic [1:0]               rule_mode,
  input  logic                     clear,
  output logic [NUM_CH-1:0]        fail_pulse,
  output logic [NUM_CH-1:0]        sticky_err,
  output logic [NUM_CH*CNT_W-1:0]  fail_cnt,
  output logic [NUM_CH-1:0]        alarm,
  output logic                     first_fail_valid,
  output logic [CH_W-1:0]          first_fail_ch,
  output logic [DATA_W-1:0]        first_fail_data
);

  logic [NUM_CH-1:0] w_fail;
  logic              w_found;
  logic [CH_W-1:0]   w_ch;
  logic [DATA_W-1:0] w_dat;
  logic              r_ff_valid;
  logic [CH_W-1:0]   r_ff_ch;
  logic [DATA_W-1:0] r_ff_data;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    data_rule_chan #(
      .DATA_W      (DATA_W),
      .CNT_W       (CNT_W),
      .ALIGN_BITS  (ALIGN_BITS),
      .FAIL_THRESH (FAIL_THRESH)
    ) u_chan (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_enable     (enable[c]),
      .i_data       (data[c*DATA_W +: DATA_W]),
      .i_rule_mode  (rule_mode),
      .i_clear      (clear),
      .o_fail       (w_fail[c]),
      .o_fail_pulse (fail_pulse[c]),
      .o_sticky_err (sticky_err[c]),
      .o_fail_cnt   (fail_cnt[c*CNT_W +: CNT_W]),
      .o_alarm      (alarm[c])
    );
  end

  // Lowest failing channel index wins
  always_comb begin
    w_found = 1'b0;
    w_ch    = '0;
    w_dat   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (w_fail[i] && !w_found) begin
        w_found = 1'b1;
        w_ch    = CH_W'(i);
        w_dat   = data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      r_ff_valid <= 1'b0;
      r_ff_ch    <= '0;
      r_ff_data  <= '0;
    end else if (!r_ff_valid && w_found) begin
      r_ff_valid <= 1'b1;
      r_ff_ch    <= w_ch;
      r_ff_data  <= w_dat;
    end
  end

  assign first_fail_valid = r_ff_valid;
  assign first_fail_ch    = r_ff_ch;
  assign first_fail_data  = r_ff_data;

endmodule

// File: tb/tb_data_rule_monitor.sv
module tb_data_rule_monitor;

  localparam int NCH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  enable;
  logic [31:0] data;
  logic [1:0]  rule_mode;
  logic        clear;

  // default instance
  logic [3:0]  fp_a, st_a, al_a;
  logic [63:0] cnt_a;
  logic        ffv_a;
  logic [1:0]  ffc_a;
  logic [7:0]  ffd_a;
  // narrow counter, threshold 1 instance
  logic [3:0]  fp_b, st_b, al_b;
  logic [7:0]  cnt_b;
  logic        ffv_b;
  logic [1:0]  ffc_b;
  logic [7:0]  ffd_b;

  always #5 clk = ~clk;

  data_rule_monitor dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .data(data),
    .rule_mode(rule_mode), .clear(clear),
    .fail_pulse(fp_a), .sticky_err(st_a), .fail_cnt(cnt_a), .alarm(al_a),
    .first_fail_valid(ffv_a), .first_fail_ch(ffc_a), .first_fail_data(ffd_a)
  );

  data_rule_monitor #(.CNT_W(2), .FAIL_THRESH(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .enable(enable), .data(data),
    .rule_mode(rule_mode), .clear(clear),
    .fail_pulse(fp_b), .sticky_err(st_b), .fail_cnt(cnt_b), .alarm(al_b),
    .first_fail_valid(ffv_b), .first_fail_ch(ffc_b), .first_fail_data(ffd_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: streak lengths and flags, per instance (0 = default, 1 = narrow)
  int thr[2]  = '{3, 1};
  int cmax[2] = '{65535, 3};
  int m_cnt[2][NCH];
  int m_streak[2][NCH];
  bit m_alarm[2][NCH];
  bit m_sticky[2][NCH];
  bit m_pulse[2][NCH];
  bit m_ffv;
  int m_ffch;
  int m_ffd;

  function automatic bit violates(input int d, input logic [1:0] m);
    return (m[0] && d == 0) || (m[1] && (d % 2) != 0);
  endfunction

  task automatic model_update();
    bit f[NCH];
    for (int c = 0; c < NCH; c++)
      f[c] = enable[c] && violates(int'(data[c*8 +: 8]), rule_mode);
    if (!rst_n || clear) begin
      for (int k = 0; k < 2; k++)
        for (int c = 0; c < NCH; c++) begin
          m_cnt[k][c] = 0; m_streak[k][c] = 0; m_alarm[k][c] = 0;
          m_sticky[k][c] = 0; m_pulse[k][c] = 0;
        end
      m_ffv = 0; m_ffch = 0; m_ffd = 0;
      return;
    end
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < NCH; c++) begin
        m_pulse[k][c] = f[c];
        if (f[c]) begin
          m_sticky[k][c] = 1;
          m_cnt[k][c] = (m_cnt[k][c] + 1 > cmax[k]) ? cmax[k] : m_cnt[k][c] + 1;
          m_streak[k][c]++;
          if (m_streak[k][c] >= thr[k]) m_alarm[k][c] = 1;
        end else if (enable[c]) begin
          m_streak[k][c] = 0;
        end
      end
    if (!m_ffv) begin
      for (int c = NCH - 1; c >= 0; c--)
        if (f[c]) begin
          m_ffv = 1; m_ffch = c; m_ffd = int'(data[c*8 +: 8]);
        end
    end
  endtask

  task automatic check_all();
    logic [3:0] e_fp[2], e_st[2], e_al[2];
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < NCH; c++) begin
        e_fp[k][c] = m_pulse[k][c];
        e_st[k][c] = m_sticky[k][c];
        e_al[k][c] = m_alarm[k][c];
      end
    chk("fail_pulse", 64'(fp_a), 64'(e_fp[0]));
    chk("sticky_err", 64'(st_a), 64'(e_st[0]));
    chk("alarm",      64'(al_a), 64'(e_al[0]));
    chk("fail_pulse_s", 64'(fp_b), 64'(e_fp[1]));
    chk("sticky_err_s", 64'(st_b), 64'(e_st[1]));
    chk("alarm_s",      64'(al_b), 64'(e_al[1]));
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("fail_cnt[%0d]", c),   64'(cnt_a[c*16 +: 16]), 64'(m_cnt[0][c]));
      chk($sformatf("fail_cnt_s[%0d]", c), 64'(cnt_b[c*2 +: 2]),   64'(m_cnt[1][c]));
    end
    chk("ff_valid", 64'(ffv_a), 64'(m_ffv));
    chk("ff_valid_s", 64'(ffv_b), 64'(m_ffv));
    if (m_ffv) begin
      chk("ff_ch",   64'(ffc_a), 64'(m_ffch));
      chk("ff_data", 64'(ffd_a), 64'(m_ffd));
      chk("ff_ch_s", 64'(ffc_b), 64'(m_ffch));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  typedef struct {
    logic [7:0]  d;
    logic        pulse;
    logic        alarm;
    logic [15:0] cnt;
    logic        ffv;
    logic [7:0]  ffd;
  } vec_t;

  vec_t tbl[8];

  initial begin
    // ch0 streak: 4,4,7,7,0,0,10,10 with mode 11, threshold 3
    tbl[0] = '{8'd4,  1'b0, 1'b0, 16'd0, 1'b0, 8'd0};
    tbl[1] = '{8'd4,  1'b0, 1'b0, 16'd0, 1'b0, 8'd0};
    tbl[2] = '{8'd7,  1'b1, 1'b0, 16'd1, 1'b1, 8'd7};
    tbl[3] = '{8'd7,  1'b1, 1'b0, 16'd2, 1'b1, 8'd7};
    tbl[4] = '{8'd0,  1'b1, 1'b1, 16'd3, 1'b1, 8'd7};
    tbl[5] = '{8'd0,  1'b1, 1'b1, 16'd4, 1'b1, 8'd7};
    tbl[6] = '{8'd10, 1'b0, 1'b1, 16'd4, 1'b1, 8'd7};
    tbl[7] = '{8'd10, 1'b0, 1'b1, 16'd4, 1'b1, 8'd7};

    rst_n = 1'b0; enable = '0; data = '0; rule_mode = 2'b11; clear = 1'b0;
    step(); step();
    chk("rst_cnt",  cnt_a, 64'd0);
    chk("rst_flags", 64'({fp_a, st_a, al_a, ffv_a}), 64'd0);
    rst_n = 1'b1;

    // directed table
    for (int unsigned i = 0; i < 8; i++) begin
      enable = 4'b0001; rule_mode = 2'b11; data = '0; data[7:0] = tbl[i].d;
      step();
      chk($sformatf("tbl%0d_pulse", i), 64'(fp_a[0]), 64'(tbl[i].pulse));
      chk($sformatf("tbl%0d_alarm", i), 64'(al_a[0]), 64'(tbl[i].alarm));
      chk($sformatf("tbl%0d_cnt", i),   64'(cnt_a[15:0]), 64'(tbl[i].cnt));
      chk($sformatf("tbl%0d_ffv", i),   64'(ffv_a), 64'(tbl[i].ffv));
      chk($sformatf("tbl%0d_ffd", i),   64'(ffd_a), 64'(tbl[i].ffd));
    end
    chk("tbl_ffch", 64'(ffc_a), 64'd0);

    // disabled ch1 with zero data, then enabled even data
    clear = 1'b1; step(); clear = 1'b0;
    enable = 4'b0000; data = '0;
    for (int i = 0; i < 5; i++) step();
    enable = 4'b0010; data[15:8] = 8'd2; step();
    chk("ch1_sticky", 64'(st_a[1]), 64'd0);
    chk("ch1_alarm",  64'(al_a[1]), 64'd0);

    // rule mode selection on ch2
    enable = 4'b0100;
    rule_mode = 2'b01; data[23:16] = 8'd7; step();
    chk("mode01_pulse", 64'(fp_a[2]), 64'd0);
    rule_mode = 2'b10; data[23:16] = 8'd0; step();
    chk("mode10_pulse", 64'(fp_a[2]), 64'd0);
    rule_mode = 2'b00;
    for (int i = 0; i < 4; i++) begin
      data[23:16] = 8'($urandom_range(0, 255)); step();
      chk("mode00_pulse", 64'(fp_a[2]), 64'd0);
    end

    // simultaneous failures on ch2 and ch3
    clear = 1'b1; step(); clear = 1'b0;
    rule_mode = 2'b11; enable = 4'b1100; data = '0;
    data[23:16] = 8'd3; data[31:24] = 8'd5; step();
    chk("simul_ffch",  64'(ffc_a), 64'd2);
    chk("simul_ffd",   64'(ffd_a), 64'd3);
    chk("simul_stk",   64'(st_a[3:2]), 64'd3);

    // counter saturation on the 2-bit instance
    clear = 1'b1; step(); clear = 1'b0;
    enable = 4'b0001; data = '0; data[7:0] = 8'd1;
    for (int i = 0; i < 6; i++) step();
    chk("sat_cnt_s", 64'(cnt_b[1:0]), 64'd3);
    chk("alarm_a0",  64'(al_a[0]), 64'd1);

    // clear together with a failing sample
    clear = 1'b1; step(); clear = 1'b0;
    chk("clr_cnt",   cnt_a, 64'd0);
    chk("clr_flags", 64'({fp_a, al_a, ffv_a}), 64'd0);

    // reset while ch0 is in WARN
    step();
    enable = '0;
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("rstw_cnt",   cnt_a, 64'd0);
    chk("rstw_flags", 64'({fp_a, st_a, al_a, ffv_a}), 64'd0);

    // random stimulus against the model
    for (int i = 0; i < 400; i++) begin
      enable    = 4'($urandom);
      rule_mode = 2'($urandom);
      for (int c = 0; c < NCH; c++)
        data[c*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3))
                                                      : 8'($urandom);
      clear = ($urandom_range(0, 29) == 0);
      rst_n = ($urandom_range(0, 59) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
